multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM: sequences the shared datapath (RegDst/ALUSrc/ToReg selects, ALU, register file,

---
 rtl/multicycle_ctrl_pkg.sv | 92 +++++++++
 rtl/multicycle_ctrl_decode.sv | 52 +++++
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction classes,
// opcode/funct values and every datapath select / ALU operation code.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    typedef enum logic [3:0] {
        ClsIllegal,
        ClsRAlu,
        ClsRShift,
        ClsJr,
        ClsAluImm,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsBne,
        ClsJ,
        ClsJal
    } instr_cls_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnSll   = 6'b000000;
    localparam logic [5:0] FnSrl   = 6'b000010;
    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnXor   = 6'b100110;
    localparam logic [5:0] FnNor   = 6'b100111;
    localparam logic [5:0] FnSlt   = 6'b101010;
    localparam logic [5:0] FnSltu  = 6'b101011;

    localparam logic [1:0] RdRt = 2'b00;
    localparam logic [1:0] RdRd = 2'b01;
    localparam logic [1:0] RdRa = 2'b10;

    localparam logic [1:0] AluSrcReg  = 2'b00;
    localparam logic [1:0] AluSrcImm  = 2'b01;
    localparam logic [1:0] AluSrcSha  = 2'b10;
    localparam logic [1:0] AluSrcZero = 2'b11;

    localparam logic [1:0] Dm2Reg  = 2'b00;
    localparam logic [1:0] Alu2Reg = 2'b01;
    localparam logic [1:0] Npc2Reg = 2'b10;

    localparam logic [1:0] NpcPc4    = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;
    localparam logic [1:0] NpcJr     = 2'b11;

    localparam logic [3:0] AluNop  = 4'd0;
    localparam logic [3:0] AluAdd  = 4'd1;
    localparam logic [3:0] AluSub  = 4'd2;
    localparam logic [3:0] AluAnd  = 4'd3;
    localparam logic [3:0] AluOr   = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluNor  = 4'd6;
    localparam logic [3:0] AluSlt  = 4'd7;
    localparam logic [3:0] AluSltu = 4'd8;
    localparam logic [3:0] AluSll  = 4'd9;
    localparam logic [3:0] AluSrl  = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;

    function automatic logic cls_is_mem(input instr_cls_e cls);
        return (cls == ClsLoad) || (cls == ClsStore);
    endfunction

    function automatic logic cls_is_rtype(input instr_cls_e cls);
        return (cls == ClsRAlu) || (cls == ClsRShift);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational instruction decoder: op/funct -> instruction class, ALU operation and
// an illegal-instruction flag for anything outside the supported subset.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_cls,
    output logic [3:0] o_alu_op,
    output logic       o_illegal
);

    instr_cls_e w_cls;

    always_comb begin
        w_cls    = ClsIllegal;
        o_alu_op = AluNop;
        case (i_op)
            OpRtype: begin
                case (i_funct)
                    FnAdd, FnAddu: begin w_cls = ClsRAlu;   o_alu_op = AluAdd;  end
                    FnSub, FnSubu: begin w_cls = ClsRAlu;   o_alu_op = AluSub;  end
                    FnAnd:         begin w_cls = ClsRAlu;   o_alu_op = AluAnd;  end
                    FnOr:          begin w_cls = ClsRAlu;   o_alu_op = AluOr;   end
                    FnXor:         begin w_cls = ClsRAlu;   o_alu_op = AluXor;  end
                    FnNor:         begin w_cls = ClsRAlu;   o_alu_op = AluNor;  end
                    FnSlt:         begin w_cls = ClsRAlu;   o_alu_op = AluSlt;  end
                    FnSltu:        begin w_cls = ClsRAlu;   o_alu_op = AluSltu; end
                    FnSll:         begin w_cls = ClsRShift; o_alu_op = AluSll;  end
                    FnSrl:         begin w_cls = ClsRShift; o_alu_op = AluSrl;  end
                    FnJr:          begin w_cls = ClsJr;     o_alu_op = AluNop;  end
                    default:       begin w_cls = ClsIllegal; o_alu_op = AluNop; end
                endcase
            end
            OpAddi:  begin w_cls = ClsAluImm; o_alu_op = AluAdd; end
            OpOri:   begin w_cls = ClsAluImm; o_alu_op = AluOr;  end
            OpLui:   begin w_cls = ClsAluImm; o_alu_op = AluLui; end
            // Address generation for loads/stores reuses the adder.
            OpLw:    begin w_cls = ClsLoad;   o_alu_op = AluAdd; end
            OpSw:    begin w_cls = ClsStore;  o_alu_op = AluAdd; end
            OpBeq:   begin w_cls = ClsBeq;    o_alu_op = AluSub; end
            OpBne:   begin w_cls = ClsBne;    o_alu_op = AluSub; end
            OpJ:     begin w_cls = ClsJ;      o_alu_op = AluNop; end
            OpJal:   begin w_cls = ClsJal;    o_alu_op = AluNop; end
            default: begin w_cls = ClsIllegal; o_alu_op = AluNop; end
        endcase
    end

    assign o_cls     = w_cls;
    assign o_illegal = (w_cls == ClsIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) driving the shared datapath.
// Define MULTICYCLE_PERF_EN to build the cycle / retired-instruction counters.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       npc_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       alu_src,
    output logic [1:0]       to_reg,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e     r_state;
    state_e     w_state_d;
    logic [3:0] w_cls_bits;
    instr_cls_e w_cls;
    logic [3:0] w_alu_op;
    logic       w_illegal;

    multicycle_ctrl_decode u_decode (
        .i_op      (op),
        .i_funct   (funct),
        .o_cls     (w_cls_bits),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    assign w_cls = instr_cls_e'(w_cls_bits);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   w_state_d = StFetch;
            StFetch:  if (mem_ready) w_state_d = StDecode;
            StDecode: begin
                if (w_illegal || (w_cls == ClsJ) || (w_cls == ClsJal) || (w_cls == ClsJr)) begin
                    w_state_d = StFetch;
                end else begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if ((w_cls == ClsBeq) || (w_cls == ClsBne)) begin
                    w_state_d = StFetch;
                end else if (cls_is_mem(w_cls)) begin
                    w_state_d = StMem;
                end else begin
                    w_state_d = StWb;
                end
            end
            // A store completes in MEM; a load still needs its write-back cycle.
            StMem: begin
                if (mem_ready) begin
                    w_state_d = (w_cls == ClsStore) ? StFetch : StWb;
                end
            end
            StWb:     w_state_d = StFetch;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        npc_op    = NpcPc4;
        reg_write = 1'b0;
        reg_dst   = RdRt;
        alu_src   = AluSrcReg;
        to_reg    = Dm2Reg;
        alu_op    = AluNop;
        illegal   = 1'b0;
        unique case (r_state)
            StIdle: begin
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    npc_op   = NpcPc4;
                end
            end
            StDecode: begin
                case (w_cls)
                    ClsJ: begin
                        pc_write = 1'b1;
                        npc_op   = NpcJump;
                    end
                    ClsJal: begin
                        pc_write  = 1'b1;
                        npc_op    = NpcJump;
                        reg_write = 1'b1;
                        reg_dst   = RdRa;
                        to_reg    = Npc2Reg;
                    end
                    ClsJr: begin
                        pc_write = 1'b1;
                        npc_op   = NpcJr;
                    end
                    default: illegal = w_illegal;
                endcase
            end
            StExec: begin
                alu_op = w_alu_op;
                case (w_cls)
                    ClsRShift:                    alu_src = AluSrcSha;
                    ClsAluImm, ClsLoad, ClsStore: alu_src = AluSrcImm;
                    default:                      alu_src = AluSrcReg;
                endcase
                if (w_cls == ClsBeq) begin
                    pc_write = zero;
                    npc_op   = NpcBranch;
                end else if (w_cls == ClsBne) begin
                    pc_write = ~zero;
                    npc_op   = NpcBranch;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (w_cls == ClsStore);
            end
            StWb: begin
                reg_write = 1'b1;
                reg_dst   = cls_is_rtype(w_cls) ? RdRd : RdRt;
                to_reg    = (w_cls == ClsLoad) ? Dm2Reg : Alu2Reg;
            end
            default: begin
            end
        endcase
    end

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;
    logic             w_retire;

    // IDLE -> FETCH is the start of the first instruction, not a retirement.
    assign w_retire = (r_state != StIdle) && (r_state != StFetch) && (w_state_d == StFetch);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instructions checked
// against per-instruction expectations (latency, write counts, selects) derived from the ISA rules.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int KR = 0, KSH = 1, KJR = 2, KAI = 3, KLW = 4, KSW = 5;
    localparam int KBEQ = 6, KBNE = 7, KJ = 8, KJAL = 9, KILL = 10;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        logic [3:0] alu;
    } ins_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  npc_op, reg_dst, alu_src, to_reg;
    logic [3:0]  alu_op;
    logic [31:0] cycle_cnt, instret_cnt;

    int   total = 0;
    int   bad = 0;
    ins_t tbl[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .npc_op      (npc_op),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .to_reg      (to_reg),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] outs();
        return {mem_req, mem_we, iord, ir_write, pc_write, npc_op, reg_write,
                reg_dst, alu_src, to_reg, alu_op, illegal};
    endfunction

    // Drive one instruction for exactly its expected length, then confirm the next fetch began.
    task automatic run_instr(input ins_t t, input int fw, input int mw, input logic zv,
                             input string tag);
        bit         ldst, taken, xfer, has_exec, writes;
        int         lat;
        int         n_req, n_iord, n_we, n_irw, n_pcw, n_rw, n_ill;
        logic [1:0] last_npc, fetch_npc, exp_npc, exp_src;
        logic [5:0] rw_f, exp_rw_f;
        logic [5:0] ex_f;
        ldst     = (t.kind == KLW) || (t.kind == KSW);
        taken    = ((t.kind == KBEQ) && zv) || ((t.kind == KBNE) && !zv);
        xfer     = (t.kind == KJ) || (t.kind == KJAL) || (t.kind == KJR);
        has_exec = !(xfer || (t.kind == KILL));
        writes   = (t.kind == KR) || (t.kind == KSH) || (t.kind == KAI) ||
                   (t.kind == KLW) || (t.kind == KJAL);
        case (t.kind)
            KJ, KJAL, KJR, KILL: lat = 2;
            KBEQ, KBNE:          lat = 3;
            KLW:                 lat = 5;
            default:             lat = 4;
        endcase
        lat = lat + fw + (ldst ? mw : 0);
        n_req = 0; n_iord = 0; n_we = 0; n_irw = 0; n_pcw = 0; n_rw = 0; n_ill = 0;
        last_npc = 2'b00; fetch_npc = 2'b11; rw_f = '0; ex_f = '0;
        for (int k = 0; k < lat; k++) begin
            op = t.op;
            funct = t.fn;
            zero = zv;
            if (k <= fw) mem_ready = (k == fw);
            else if (ldst && k >= fw + 3) mem_ready = (k == fw + 3 + mw);
            else mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_req += int'(mem_req);
            n_iord += int'(iord);
            n_we += int'(mem_we);
            n_irw += int'(ir_write);
            n_pcw += int'(pc_write);
            n_rw += int'(reg_write);
            n_ill += int'(illegal);
            if (pc_write && ir_write) fetch_npc = npc_op;
            if (pc_write && !ir_write) last_npc = npc_op;
            if (reg_write) rw_f = {reg_dst, to_reg, alu_src};
            if (k == fw + 2) ex_f = {alu_src, alu_op};
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        chk({tag, "/next_fetch"}, {29'd0, mem_req, iord, ir_write}, 32'b100);
        chk({tag, "/mem_req_cycles"}, n_req, fw + 1 + (ldst ? mw + 1 : 0));
        chk({tag, "/iord_cycles"}, n_iord, ldst ? mw + 1 : 0);
        chk({tag, "/mem_we_cycles"}, n_we, (t.kind == KSW) ? mw + 1 : 0);
        chk({tag, "/ir_write_cycles"}, n_irw, 1);
        chk({tag, "/pc_write_cycles"}, n_pcw, (xfer || taken) ? 2 : 1);
        chk({tag, "/fetch_npc"}, fetch_npc, NpcPc4);
        exp_npc = (t.kind == KJ || t.kind == KJAL) ? NpcJump :
                  (t.kind == KJR) ? NpcJr : taken ? NpcBranch : NpcPc4;
        chk({tag, "/npc_op"}, last_npc, exp_npc);
        chk({tag, "/reg_write_cycles"}, n_rw, writes ? 1 : 0);
        chk({tag, "/illegal_cycles"}, n_ill, (t.kind == KILL) ? 1 : 0);
        if (writes) begin
            case (t.kind)
                KJAL:    exp_rw_f = {RdRa, Npc2Reg, AluSrcReg};
                KR, KSH: exp_rw_f = {RdRd, Alu2Reg, AluSrcReg};
                KLW:     exp_rw_f = {RdRt, Dm2Reg, AluSrcReg};
                default: exp_rw_f = {RdRt, Alu2Reg, AluSrcReg};
            endcase
            chk({tag, "/wb_selects"}, rw_f, exp_rw_f);
        end
        if (has_exec) begin
            exp_src = (t.kind == KSH) ? AluSrcSha :
                      (t.kind == KAI || ldst) ? AluSrcImm : AluSrcReg;
            chk({tag, "/exec_alu"}, ex_f, {exp_src, t.alu});
        end
    endtask

    initial begin
        tbl.push_back('{6'h00, 6'h20, KR, AluAdd});
        tbl.push_back('{6'h00, 6'h21, KR, AluAdd});
        tbl.push_back('{6'h00, 6'h22, KR, AluSub});
        tbl.push_back('{6'h00, 6'h23, KR, AluSub});
        tbl.push_back('{6'h00, 6'h24, KR, AluAnd});
        tbl.push_back('{6'h00, 6'h25, KR, AluOr});
        tbl.push_back('{6'h00, 6'h26, KR, AluXor});
        tbl.push_back('{6'h00, 6'h27, KR, AluNor});
        tbl.push_back('{6'h00, 6'h2a, KR, AluSlt});
        tbl.push_back('{6'h00, 6'h2b, KR, AluSltu});
        tbl.push_back('{6'h00, 6'h00, KSH, AluSll});
        tbl.push_back('{6'h00, 6'h02, KSH, AluSrl});
        tbl.push_back('{6'h00, 6'h08, KJR, AluNop});
        tbl.push_back('{6'h08, 6'h08, KAI, AluAdd});
        tbl.push_back('{6'h0d, 6'h25, KAI, AluOr});
        tbl.push_back('{6'h0f, 6'h00, KAI, AluLui});
        tbl.push_back('{6'h23, 6'h20, KLW, AluAdd});
        tbl.push_back('{6'h2b, 6'h01, KSW, AluAdd});
        tbl.push_back('{6'h04, 6'h08, KBEQ, AluSub});
        tbl.push_back('{6'h05, 6'h00, KBNE, AluSub});
        tbl.push_back('{6'h02, 6'h08, KJ, AluNop});
        tbl.push_back('{6'h03, 6'h20, KJAL, AluNop});
        tbl.push_back('{6'h3f, 6'h00, KILL, AluNop});
        tbl.push_back('{6'h00, 6'h01, KILL, AluNop});

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        chk("reset_cycle_cnt", cycle_cnt, 0);
        chk("reset_instret_cnt", instret_cnt, 0);
        rstn = 1'b1;
        #1;
        chk("idle_outputs", outs(), 0);
        @(negedge clk);
        #1;
        chk("first_fetch", {29'd0, mem_req, iord, mem_we}, 32'b100);

        run_instr(tbl[0], 0, 0, 1'b0, "add");
        run_instr(tbl[16], 0, 3, 1'b0, "lw_wait3");
        run_instr(tbl[18], 0, 0, 1'b1, "beq_taken");
        run_instr(tbl[18], 0, 0, 1'b0, "beq_not_taken");
        run_instr(tbl[19], 0, 0, 1'b0, "bne_taken");
        run_instr(tbl[19], 0, 0, 1'b1, "bne_not_taken");
        run_instr(tbl[21], 0, 0, 1'b0, "jal");
        run_instr(tbl[22], 0, 0, 1'b0, "illegal_op3f");
        run_instr(tbl[17], 1, 2, 1'b0, "sw_wait");
        run_instr(tbl[12], 2, 0, 1'b1, "jr");
        run_instr(tbl[10], 0, 0, 1'b0, "sll");

        // Abandon a load while it waits in MEM.
        op = 6'h23;
        funct = 6'h00;
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 0);
            #1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        chk("lw_in_mem", {30'd0, mem_req, iord}, 32'b11);
        #1;
        rstn = 1'b0;
        #1;
        chk("reset_mid_mem", outs(), 0);
        @(negedge clk);
        #1;
        chk("held_reset", outs(), 0);
        rstn = 1'b1;
        #1;
        chk("idle_after_release", outs(), 0);
        @(negedge clk);
        #1;
        chk("fetch_after_idle", {29'd0, mem_req, iord, mem_we}, 32'b100);

        run_instr(tbl[0], 0, 0, 1'b0, "perf_add");
        run_instr(tbl[16], 0, 0, 1'b0, "perf_lw");
        run_instr(tbl[17], 0, 0, 1'b0, "perf_sw");
        run_instr(tbl[20], 0, 0, 1'b0, "perf_j");
`ifdef MULTICYCLE_PERF_EN
        chk("perf_instret", instret_cnt, 4);
        chk("perf_cycles", cycle_cnt, 15);
`else
        chk("perf_instret_tied", instret_cnt, 0);
        chk("perf_cycles_tied", cycle_cnt, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            int   idx;
            int   fw;
            int   mw;
            logic zv;
            idx = int'($urandom_range(0, 23));
            fw  = int'($urandom_range(0, 3));
            mw  = int'($urandom_range(0, 3));
            zv  = 1'($urandom_range(0, 1));
            run_instr(tbl[idx], fw, mw, zv, $sformatf("rand%0d_i%0d", n, idx));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
